// File: rtl/fullchip_sequencer_if.sv
// rtl/fullchip_sequencer_if.sv - host stream and fullchip control bundle for fullchip_sequencer
interface fullchip_sequencer_if #(
   parameter int BW      = 8,
   parameter int PR      = 16,
   parameter int BW_PSUM = 20
);
   logic                  in_valid;
   logic [PR*BW-1:0]      in_data;
   logic                  in_ready;
   logic [PR*BW-1:0]      mem_in;
   logic [16:0]           inst;
   logic                  acc;
   logic                  div;
   logic                  fifo_ext_rd;
   logic [BW_PSUM+3:0]    sum_in;
   logic                  out_valid;
   logic [BW_PSUM+3:0]    out_data;

   modport master (
      input  in_valid, in_data, sum_in,
      output in_ready, mem_in, inst, acc, div, fifo_ext_rd, out_valid, out_data
   );

   modport slave (
      output in_valid, in_data, sum_in,
      input  in_ready, mem_in, inst, acc, div, fifo_ext_rd, out_valid, out_data
   );
endinterface

// File: rtl/fullchip_sequencer.sv
// rtl/fullchip_sequencer.sv - fullchip instruction sequencer; SEQ_PERF_CNT_EN adds cyc_count
module fullchip_sequencer #(
   parameter int BW      = 8,
   parameter int PR      = 16,
   parameter int COL     = 8,
   parameter int N       = 8,
   parameter int BW_PSUM = 20,
   parameter int GAP     = 10,
   parameter int DRAIN   = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   fullchip_sequencer_if.master bus,
   output logic                 busy,
   output logic                 done
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0]          cyc_count
`endif
);
   localparam int CW = 16;
   localparam int DW = PR * BW;
   localparam int SW = BW_PSUM + 4;

   typedef enum logic [3:0] {
      S_IDLE, S_QWR, S_KWR, S_GAP1, S_KLOAD, S_KTAIL, S_GAP2, S_EXEC,
      S_GAP3, S_O2P, S_GAP4, S_P2S, S_DIV, S_DRAIN, S_SRD
   } state_t;

   state_t        state, state_n, succ;
   logic [CW-1:0] cnt, cnt_n, len;
   logic [4:0]    beat, beat_n;
   logic          accept;

   logic          in_ready_q, in_ready_d;
   logic [DW-1:0] mem_in_q;
   logic [16:0]   inst_q, inst_d;
   logic          acc_q, acc_d, div_q, div_d, rd_q, rd_d;
   logic          out_valid_q;
   logic [SW-1:0] out_data_q;

   logic          ofifo, exe, load, qrd, qwr, krd, kwr, prd, pwr;
   logic [3:0]    qk_add, p_add, add4;

   // in_ready is a registered copy of "state is QWR or KWR", so it is safe to gate on
   assign accept = bus.in_valid & in_ready_q;

   // State, cycle-in-phase and beat counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         beat  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         beat  <= beat_n;
      end
   end

   // Next-state: host-paced load phases, then fixed-length timed phases in order
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      beat_n  = beat;
      succ    = (state == S_SRD) ? S_IDLE : state_t'(state + 4'd1);
      case (state)
         S_GAP1, S_GAP2, S_GAP3, S_GAP4: len = CW'(GAP);
         S_KLOAD:                        len = CW'(COL + 1);
         S_EXEC, S_O2P, S_P2S:           len = CW'(N);
         S_DRAIN:                        len = CW'(DRAIN);
         S_SRD:                          len = CW'(N + 3);
         default:                        len = CW'(1);
      endcase
      case (state)
         S_IDLE: begin
            cnt_n  = '0;
            beat_n = '0;
            if (start) state_n = S_QWR;
         end
         S_QWR: begin
            cnt_n = '0;
            if (accept) begin
               if (beat == 5'(N - 1)) begin
                  state_n = S_KWR;
                  beat_n  = '0;
               end else begin
                  beat_n = beat + 5'd1;
               end
            end
         end
         S_KWR: begin
            cnt_n = '0;
            if (accept) begin
               if (beat == 5'(COL - 1)) begin
                  state_n = S_GAP1;
                  beat_n  = '0;
               end else begin
                  beat_n = beat + 5'd1;
               end
            end
         end
         default: begin
            if (cnt == len - CW'(1)) begin
               state_n = succ;
               cnt_n   = '0;
            end
         end
      endcase
   end

   // Output decode for the coming cycle; write pulses follow the beat accepted this cycle
   always_comb begin
      in_ready_d = (state_n == S_QWR) || (state_n == S_KWR);
      acc_d  = 1'b0;
      div_d  = 1'b0;
      rd_d   = 1'b0;
      ofifo  = 1'b0;
      exe    = 1'b0;
      load   = 1'b0;
      qrd    = 1'b0;
      qwr    = 1'b0;
      krd    = 1'b0;
      kwr    = 1'b0;
      prd    = 1'b0;
      pwr    = 1'b0;
      qk_add = 4'd0;
      p_add  = 4'd0;
      add4   = cnt_n[3:0];
      case (state_n)
         S_KLOAD: begin
            load   = 1'b1;
            krd    = (cnt_n != '0);
            qk_add = (cnt_n > CW'(1)) ? add4 - 4'd1 : 4'd0;
         end
         S_KTAIL: load = 1'b1;
         S_EXEC: begin
            exe    = 1'b1;
            qrd    = 1'b1;
            qk_add = add4;
         end
         S_O2P: begin
            ofifo = 1'b1;
            pwr   = 1'b1;
            p_add = add4;
         end
         S_P2S: begin
            acc_d = 1'b1;
            prd   = 1'b1;
            p_add = add4;
         end
         S_DIV:   div_d = 1'b1;
         S_SRD:   rd_d  = 1'b1;
         default: ;
      endcase
      if ((state == S_QWR) || (state == S_KWR)) begin
         qk_add = accept ? beat[3:0] : inst_q[15:12];
         qwr    = accept && (state == S_QWR);
         kwr    = accept && (state == S_KWR);
      end
      inst_d = {ofifo, qk_add, p_add, exe, load, qrd, qwr, krd, kwr, prd, pwr};
   end

   // Registered outputs; a result beat appears the cycle after each post-fill sfp read
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_ready_q  <= 1'b0;
         mem_in_q    <= '0;
         inst_q      <= '0;
         acc_q       <= 1'b0;
         div_q       <= 1'b0;
         rd_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         if (accept) mem_in_q <= bus.in_data;
         inst_q      <= inst_d;
         acc_q       <= acc_d;
         div_q       <= div_d;
         rd_q        <= rd_d;
         out_valid_q <= (state == S_SRD) && (cnt >= CW'(3));
         if ((state == S_SRD) && (cnt >= CW'(3))) out_data_q <= bus.sum_in;
         busy        <= (state_n != S_IDLE);
         done        <= (state != S_IDLE) && (state_n == S_IDLE);
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.mem_in      = mem_in_q;
   assign bus.inst        = inst_q;
   assign bus.acc         = acc_q;
   assign bus.div         = div_q;
   assign bus.fifo_ext_rd = rd_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;

`ifdef SEQ_PERF_CNT_EN
   // Busy-cycle counter: cleared by an accepted start, saturating, held between runs
   always_ff @(posedge clk) begin
      if (!reset) begin
         cyc_count <= '0;
      end else if ((state == S_IDLE) && start) begin
         cyc_count <= '0;
      end else if (busy && (cyc_count != 16'hFFFF)) begin
         cyc_count <= cyc_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fullchip_sequencer.sv
// tb/tb_fullchip_sequencer.sv - self-checking bench for fullchip_sequencer
`timescale 1ns/1ps
module tb_fullchip_sequencer;
   localparam int BW = 8, PR = 16, COL = 8, N = 8, BW_PSUM = 20, GAP = 10, DRAIN = 3;
   localparam int DW = PR * BW;
   localparam int SW = BW_PSUM + 4;
   localparam logic [7:0] C_EXE = 8'h80, C_LOAD = 8'h40, C_QRD = 8'h20, C_QWR = 8'h10;
   localparam logic [7:0] C_KRD = 8'h08, C_KWR = 8'h04, C_PRD = 8'h02, C_PWR = 8'h01;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic busy, done;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0] cyc_count;
`endif

   fullchip_sequencer_if #(.BW(BW), .PR(PR), .BW_PSUM(BW_PSUM)) bus ();

   fullchip_sequencer #(.BW(BW), .PR(PR), .COL(COL), .N(N), .BW_PSUM(BW_PSUM),
                        .GAP(GAP), .DRAIN(DRAIN)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus.master), .busy(busy), .done(done)
`ifdef SEQ_PERF_CNT_EN
      , .cyc_count(cyc_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] mk_inst(input bit ofifo, input int qa, input int pa,
                                           input logic [7:0] ctl);
      return {ofifo, 4'(qa), 4'(pa), ctl};
   endfunction

   function automatic logic [DW-1:0] vec(input int id, input int i);
      logic [7:0] b;
      b = 8'(id * 40 + i + 1);
      return {PR{b}};
   endfunction

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [16:0] inst;
      logic        acc;
      logic        div;
      logic        rd;
   } step_t;

   step_t         sched[$];
   int            mode = 0;
   int            qn = 0, kn = 0, rdn = 0;
   bit            m_in_ready = 0, m_acc = 0, m_div = 0, m_rd = 0, m_busy = 0, m_done = 0, m_ov = 0;
   logic [16:0]   m_inst = '0;
   logic [SW-1:0] m_od = '0;
   logic [DW-1:0] m_mem = '0;
   logic [15:0]   m_cyc = '0;

   task automatic push_n(input step_t s, input int n);
      for (int c = 0; c < n; c++) sched.push_back(s);
   endtask

   task automatic build_schedule();
      step_t s;
      sched.delete();
      s = '0;
      push_n(s, GAP);
      for (int c = 0; c <= COL; c++) begin
         s = '0;
         s.inst = mk_inst(0, (c >= 2) ? c - 1 : 0, 0, C_LOAD | ((c >= 1) ? C_KRD : 8'h00));
         sched.push_back(s);
      end
      s = '0; s.inst = mk_inst(0, 0, 0, C_LOAD); sched.push_back(s);
      s = '0; push_n(s, GAP);
      for (int c = 0; c < N; c++) begin
         s = '0; s.inst = mk_inst(0, c, 0, C_EXE | C_QRD); sched.push_back(s);
      end
      s = '0; push_n(s, GAP);
      for (int c = 0; c < N; c++) begin
         s = '0; s.inst = mk_inst(1, 0, c, C_PWR); sched.push_back(s);
      end
      s = '0; push_n(s, GAP);
      for (int c = 0; c < N; c++) begin
         s = '0; s.inst = mk_inst(0, 0, c, C_PRD); s.acc = 1'b1; sched.push_back(s);
      end
      s = '0; s.div = 1'b1; sched.push_back(s);
      s = '0; push_n(s, DRAIN);
      s = '0; s.rd = 1'b1; push_n(s, N + 3);
   endtask

   // Advance the model on each clock edge from the inputs the DUT sees at that edge
   always @(posedge clk) begin
      bit    prev_rd, prev_busy, took, started;
      step_t st;
      prev_rd   = m_rd;
      prev_busy = m_busy;
      started   = 1'b0;
      if (!reset) begin
         mode = 0; m_in_ready = 0; m_acc = 0; m_div = 0; m_rd = 0; m_busy = 0;
         m_done = 0; m_ov = 0; m_inst = '0; m_od = '0; m_mem = '0; m_cyc = '0;
         sched.delete();
      end else begin
         m_ov   = 1'b0;
         m_done = 1'b0;
         if (prev_rd) begin
            if (rdn >= 3) begin
               m_ov = 1'b1;
               m_od = SW'(rdn + 1);
            end
            rdn++;
         end
         if (mode == 0) begin
            if (start) begin
               mode = 1; m_busy = 1; m_in_ready = 1; qn = 0; kn = 0; rdn = 0; started = 1'b1;
            end
         end else if (mode == 1) begin
            took = bus.in_valid && m_in_ready;
            m_inst[4] = 1'b0;
            m_inst[2] = 1'b0;
            if (took) begin
               m_mem = bus.in_data;
               if (qn < N) begin
                  m_inst = mk_inst(0, qn, 0, C_QWR);
                  qn++;
               end else begin
                  m_inst = mk_inst(0, kn, 0, C_KWR);
                  kn++;
               end
            end
            if (kn == COL) begin
               m_in_ready = 0;
               build_schedule();
               void'(sched.pop_front());
               mode = 2;
            end
         end else begin
            if (sched.size() > 0) begin
               st = sched.pop_front();
               m_inst = st.inst; m_acc = st.acc; m_div = st.div; m_rd = st.rd;
            end else begin
               m_inst = '0; m_acc = 0; m_div = 0; m_rd = 0; m_busy = 0; m_done = 1; mode = 0;
            end
         end
         if (started) m_cyc = '0;
         else if (prev_busy && (m_cyc != 16'hFFFF)) m_cyc = m_cyc + 16'd1;
      end
   end

   // Compare DUT outputs with the model every cycle, away from the active edge
   always @(negedge clk) begin
      if (checking) begin
         chk("in_ready", bus.in_ready, m_in_ready);
         chk("inst", bus.inst, m_inst);
         chk("acc", bus.acc, m_acc);
         chk("div", bus.div, m_div);
         chk("fifo_ext_rd", bus.fifo_ext_rd, m_rd);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("out_valid", bus.out_valid, m_ov);
         chk("mem_in", bus.mem_in, m_mem);
         if (m_ov) chk("out_data", bus.out_data, m_od);
`ifdef SEQ_PERF_CNT_EN
         chk("cyc_count", cyc_count, m_cyc);
`endif
      end
   end

   // ---------------- activity monitor for hand-computed totals ----------------
   int           mc[11];
   logic [SW-1:0] outs[$];
   initial for (int k = 0; k < 11; k++) mc[k] = 0;

   // Accumulate per-signal high-cycle counts and collect result beats
   always @(negedge clk) begin
      if (bus.inst[4] === 1'b1) mc[0]++;
      if (bus.inst[2] === 1'b1) mc[1]++;
      if (bus.inst[6] === 1'b1) mc[2]++;
      if (bus.inst[3] === 1'b1) mc[3]++;
      if (bus.inst[7] === 1'b1) mc[4]++;
      if (bus.inst[16] === 1'b1) mc[5]++;
      if (bus.inst[1] === 1'b1) mc[6]++;
      if (bus.div === 1'b1) mc[7]++;
      if (bus.fifo_ext_rd === 1'b1) mc[8]++;
      if (busy === 1'b1) mc[9]++;
      if (done === 1'b1) mc[10]++;
      if (bus.out_valid === 1'b1) outs.push_back(bus.out_data);
   end

   // Fullchip stand-in: presents 1, 2, 3, ... on sum_in across consecutive sfp reads
   initial begin
      int rd_ctr;
      rd_ctr = 0;
      bus.sum_in = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.fifo_ext_rd === 1'b1) begin
            bus.sum_in = SW'(rd_ctr + 1);
            rd_ctr++;
         end else if (busy !== 1'b1) begin
            rd_ctr = 0;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_run(input int id, input int stall_at, input bit abort, input int busy_exp);
      int  base[11];
      int  ob, i, budget, names_i;
      bit  taken, fin;
      int  exp_cnt[11];
      string nm[11];
      nm = '{"qwr_cycles", "kwr_cycles", "load_cycles", "krd_cycles", "exe_cycles",
             "o2p_cycles", "p2s_cycles", "div_cycles", "srd_cycles", "busy_cycles", "done_pulses"};
      exp_cnt = '{8, 8, 10, 8, 8, 8, 8, 1, 11, busy_exp, 1};
      base = mc;
      ob   = outs.size();
      start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = vec(id, 0);
      i = 0;
      budget = 0;
      while (i < N + COL && budget < 200) begin
         @(negedge clk);
         taken = bus.in_valid && bus.in_ready;
         tick();
         start = 1'b0;
         budget++;
         if (taken) begin
            i++;
            if (i == stall_at) begin
               bus.in_valid = 1'b0;
               repeat (3) tick();
            end
            bus.in_valid = (i < N + COL);
            bus.in_data  = vec(id, i);
         end
      end
      chk("beats_accepted", 32'(i), 32'(N + COL));
      if (abort) begin
         budget = 0;
         while (bus.inst[7] !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
         end
         chk("exec_reached", bus.inst[7], 1'b1);
         tick();
         tick();
         reset = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("rst_inst", bus.inst, 17'h0);
         chk("rst_acc_div_rd", {bus.acc, bus.div, bus.fifo_ext_rd}, 3'b000);
         chk("rst_busy", busy, 1'b0);
         chk("rst_in_ready", bus.in_ready, 1'b0);
         @(posedge clk);
         #2;
         reset = 1'b1;
         tick();
      end else begin
         fin = 1'b0;
         budget = 0;
         while (!fin && budget < 400) begin
            @(negedge clk);
            if (budget == 20) start = 1'b1;
            if (budget == 21) start = 1'b0;
            fin = (done === 1'b1);
            budget++;
         end
         chk("run_done", fin, 1'b1);
         @(negedge clk);
         chk("busy_after_done", busy, 1'b0);
         for (names_i = 0; names_i < 11; names_i++)
            chk(nm[names_i], 32'(mc[names_i] - base[names_i]), 32'(exp_cnt[names_i]));
         chk("out_beats", 32'(outs.size() - ob), 32'(N));
         for (int k = 0; k < N && ob + k < outs.size(); k++)
            chk("out_value", outs[ob + k], SW'(k + 4));
`ifdef SEQ_PERF_CNT_EN
         chk("cyc_count_total", cyc_count, 16'(busy_exp));
`endif
         tick();
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      reset = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #2;
      checking = 1'b1;
      tick();
      @(negedge clk);
      chk("reset_inst", bus.inst, 17'h0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_in_ready", bus.in_ready, 1'b0);
      chk("reset_out_valid", bus.out_valid, 1'b0);
      tick();
      start = 1'b0;
      reset = 1'b1;
      tick();
      do_run(1, -1, 1'b0, 105);
      do_run(2, 3, 1'b0, 108);
      do_run(3, -1, 1'b1, 0);
      do_run(4, -1, 1'b0, 105);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
